// File: rtl/double_matrix_normalize.sv
// double_matrix_normalize: scales a SIZE_A x SIZE_B matrix of IEEE-754 doubles
// by 1/norm. The reciprocal is computed once, then one row is issued per cycle
// into SIZE_B multipliers.
// Ports: clk, rst (async, active-low), start (level request held until f),
//        mat (flat, row-major, element [i][j] at bits (i*SIZE_B+j)*64),
//        norm (divisor), result (flat, same layout), err (bad norm or
//        non-finite/underflowing product), f (finished, held in DONE).
module double_matrix_normalize #(
    parameter int SIZE_A   = 8,
    parameter int SIZE_B   = 8,
    parameter int CYCLES_D = 24,
    parameter int CYCLES_M = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SIZE_A*SIZE_B*64-1:0]  mat,
    input  logic [63:0]                  norm,
    output logic [SIZE_A*SIZE_B*64-1:0]  result,
    output logic                         err,
    output logic                         f
);

    localparam int CW = $clog2(CYCLES_D + SIZE_A + CYCLES_M + 1);
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam logic [63:0] ONE = 64'h3FF0000000000000;

    typedef enum logic [2:0] {
        IDLE, RECIP, SCALE, DRAIN, DONE
    } state_t;

    // Round-to-nearest-even multiply. Subnormal inputs are treated as zero.
    // Returns {overflow, underflow, value}; non-finite results flag overflow.
    function automatic logic [65:0] fp_mul(input logic [63:0] a,
                                           input logic [63:0] b);
        logic               s, za, zb, ia, ib, na, nb, g, st;
        logic [10:0]        ea, eb;
        logic [105:0]       prod;
        logic [52:0]        mant;
        logic [53:0]        mr;
        logic [51:0]        fr;
        logic signed [13:0] e;
        logic [65:0]        r;
        s    = a[63] ^ b[63];
        ea   = a[62:52];
        eb   = b[62:52];
        za   = (ea == 11'h000);
        zb   = (eb == 11'h000);
        ia   = (ea == 11'h7ff);
        ib   = (eb == 11'h7ff);
        na   = ia && (a[51:0] != 52'h0);
        nb   = ib && (b[51:0] != 52'h0);
        prod = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e    = $signed(14'(ea)) + $signed(14'(eb)) - 14'sd1023;
        if (prod[105]) begin
            mant = prod[105:53];
            g    = prod[52];
            st   = |prod[51:0];
            e    = e + 14'sd1;
        end else begin
            mant = prod[104:52];
            g    = prod[51];
            st   = |prod[50:0];
        end
        mr = {1'b0, mant} + 54'(g & (st | mant[0]));
        if (mr[53]) begin
            fr = mr[52:1];
            e  = e + 14'sd1;
        end else begin
            fr = mr[51:0];
        end
        if (na | nb | (ia & zb) | (ib & za))
            r = {2'b10, 64'h7FF8000000000000};
        else if (ia | ib)
            r = {2'b10, s, 11'h7ff, 52'h0};
        else if (za | zb)
            r = {2'b00, s, 63'h0};
        else if (e >= 14'sd2047)
            r = {2'b10, s, 11'h7ff, 52'h0};
        else if (e <= 14'sd0)
            r = {2'b01, s, 63'h0};
        else
            r = {2'b00, s, e[10:0], fr};
        return r;
    endfunction

    // Round-to-nearest-even divide a/b. The quotient mantissa is formed by
    // dividing {1.fa} << 55 by {1.fb}, which leaves 55 or 56 significant bits.
    function automatic logic [63:0] fp_div(input logic [63:0] a,
                                           input logic [63:0] b);
        logic               s, za, zb, ia, ib, na, nb, g, st;
        logic [10:0]        ea, eb;
        logic [107:0]       num;
        logic [55:0]        q;
        logic [52:0]        rem;
        logic [52:0]        mant;
        logic [53:0]        mr;
        logic [51:0]        fr;
        logic signed [13:0] e;
        logic [63:0]        r;
        s   = a[63] ^ b[63];
        ea  = a[62:52];
        eb  = b[62:52];
        za  = (ea == 11'h000);
        zb  = (eb == 11'h000);
        ia  = (ea == 11'h7ff);
        ib  = (eb == 11'h7ff);
        na  = ia && (a[51:0] != 52'h0);
        nb  = ib && (b[51:0] != 52'h0);
        num = {1'b1, a[51:0], 55'h0};
        q   = 56'(num / 108'({1'b1, b[51:0]}));
        rem = 53'(num % 108'({1'b1, b[51:0]}));
        e   = $signed(14'(ea)) - $signed(14'(eb)) + 14'sd1022;
        if (q[55]) begin
            mant = q[55:3];
            g    = q[2];
            st   = (|q[1:0]) | (|rem);
            e    = e + 14'sd1;
        end else begin
            mant = q[54:2];
            g    = q[1];
            st   = q[0] | (|rem);
        end
        mr = {1'b0, mant} + 54'(g & (st | mant[0]));
        if (mr[53]) begin
            fr = mr[52:1];
            e  = e + 14'sd1;
        end else begin
            fr = mr[51:0];
        end
        if (na | nb | (ia & ib) | (za & zb))
            r = 64'h7FF8000000000000;
        else if (ia | zb)
            r = {s, 11'h7ff, 52'h0};
        else if (za | ib)
            r = {s, 63'h0};
        else if (e >= 14'sd2047)
            r = {s, 11'h7ff, 52'h0};
        else if (e <= 14'sd0)
            r = {s, 63'h0};
        else
            r = {s, e[10:0], fr};
        return r;
    endfunction

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic [63:0]      norm_q, recip_q;
    logic [63:0]      mat_q [SIZE_A][SIZE_B];
    logic [63:0]      res_q [SIZE_A][SIZE_B];
    logic [63:0]      dpipe [CYCLES_D-1];
    logic [65:0]      mpipe [CYCLES_M][SIZE_B];
    logic             tv    [CYCLES_M];
    logic [RW-1:0]    tr    [CYCLES_M];
    logic             en, issue, bad_norm;
    logic [RW-1:0]    row;

    assign bad_norm = (norm[62:52] == 11'h7ff) |
                      (norm[62:0] == 63'h0) | norm[63];
    assign en    = (state == RECIP) | (state == SCALE) | (state == DRAIN);
    assign issue = (state == SCALE);
    assign row   = issue ? count[RW-1:0] : '0;
    assign f     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = bad_norm ? DONE : RECIP;
            RECIP: if (count == CW'(CYCLES_D - 1)) state_n = SCALE;
            SCALE: if (count == CW'(SIZE_A - 1)) state_n = DRAIN;
            DRAIN: if (count == CW'(CYCLES_M - 1)) state_n = DONE;
            DONE:  if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Divider and multiplier pipes only advance while the operation runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CYCLES_D - 1; i++) dpipe[i] <= '0;
            for (int i = 0; i < CYCLES_M; i++) begin
                tv[i] <= 1'b0;
                tr[i] <= '0;
                for (int j = 0; j < SIZE_B; j++) mpipe[i][j] <= '0;
            end
        end else if (en) begin
            dpipe[0] <= fp_div(ONE, norm_q);
            for (int i = 1; i < CYCLES_D - 1; i++) dpipe[i] <= dpipe[i-1];
            tv[0] <= issue;
            tr[0] <= row;
            for (int j = 0; j < SIZE_B; j++)
                mpipe[0][j] <= fp_mul(mat_q[row][j], recip_q);
            for (int i = 1; i < CYCLES_M; i++) begin
                tv[i] <= tv[i-1];
                tr[i] <= tr[i-1];
                for (int j = 0; j < SIZE_B; j++) mpipe[i][j] <= mpipe[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            err     <= 1'b0;
            norm_q  <= '0;
            recip_q <= '0;
            for (int i = 0; i < SIZE_A; i++)
                for (int j = 0; j < SIZE_B; j++) begin
                    mat_q[i][j] <= '0;
                    res_q[i][j] <= '0;
                end
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < SIZE_A; i++)
                        for (int j = 0; j < SIZE_B; j++)
                            mat_q[i][j] <= mat[(i*SIZE_B+j)*64 +: 64];
                    norm_q <= norm;
                    count  <= '0;
                    err    <= bad_norm;
                    if (bad_norm)
                        for (int i = 0; i < SIZE_A; i++)
                            for (int j = 0; j < SIZE_B; j++)
                                res_q[i][j] <= '0;
                end
                // recip_q is the divider's final stage.
                RECIP: if (count == CW'(CYCLES_D - 1)) begin
                    recip_q <= dpipe[CYCLES_D-2];
                    count   <= '0;
                end else begin
                    count <= count + CW'(1);
                end
                SCALE: count <= (count == CW'(SIZE_A - 1)) ? '0 : count + CW'(1);
                DRAIN: count <= (count == CW'(CYCLES_M - 1)) ? '0 : count + CW'(1);
                default: ;
            endcase
            if (en && tv[CYCLES_M-1]) begin
                for (int j = 0; j < SIZE_B; j++) begin
                    res_q[tr[CYCLES_M-1]][j] <= mpipe[CYCLES_M-1][j][63:0];
                    if (|mpipe[CYCLES_M-1][j][65:64]) err <= 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < SIZE_A; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE_B; gj++) begin : g_col
            assign result[(gi*SIZE_B+gj)*64 +: 64] = res_q[gi][gj];
        end
    end

endmodule
